// File: rtl/memory_reader_pkg.sv
// Shared types for the memory-side read path: register-width word, reader
// FSM state encoding and the default read-abort budget.
// Imported by memory_reader.
package memory_reader_pkg;

    typedef logic [31:0] regval_t;

    // Reader FSM state encoding, kept as plain constants for legacy tools
    typedef logic [1:0] reader_state_t;
    localparam reader_state_t ST_IDLE    = 2'd0;
    localparam reader_state_t ST_READ    = 2'd1;
    localparam reader_state_t ST_WAIT    = 2'd2;
    localparam reader_state_t ST_RESPOND = 2'd3;

    // Default cycles from read issue to abort when the timeout build is used
    localparam int MR_TIMEOUT_DEFAULT = 255;

    localparam regval_t WORD_ADDR_MASK = 32'hFFFF_FFFC;

    // Drop the byte offset so addresses compare and issue as word addresses
    function automatic regval_t word_align(input regval_t addr);
        return addr & WORD_ADDR_MASK;
    endfunction

endpackage

// File: rtl/memory_reader.sv
// Cache-miss read controller: one outstanding single-word Avalon-MM read.
// Latency: 3 cycles + waitrequest cycles + (readdatavalid delay - 1).
// Backpressure: holds avm_read/avm_address stable under avm_waitrequest;
// waits indefinitely for readdatavalid unless MEMORY_READER_TIMEOUT_EN is defined.
module memory_reader
    import memory_reader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MR_TIMEOUT_DEFAULT
) (
    input  logic    clock,
    input  logic    reset_n,
    input  logic    request_enable,
    input  regval_t request_address,
    output logic    data_valid,
    output regval_t data,
    output regval_t avm_address,
    output logic    avm_read,
    input  logic    avm_waitrequest,
    input  regval_t avm_readdata,
    input  logic    avm_readdatavalid,
    output logic    timeout_error
);

    reader_state_t r_state;
    regval_t       r_pending_address;
    regval_t       r_data;
    logic          w_timeout;
    logic          w_busy;

    assign w_busy = (r_state == ST_READ) || (r_state == ST_WAIT);

`ifdef MEMORY_READER_TIMEOUT_EN
    localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT_CYCLES);

    logic [15:0] r_timeout_count;

    // Count cycles spent on the bus; cleared in IDLE so every issue starts at 0
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_timeout_count <= '0;
        end else if (r_state == ST_IDLE) begin
            r_timeout_count <= '0;
        end else if (w_busy && !w_timeout) begin
            r_timeout_count <= r_timeout_count + 16'd1;
        end
    end

    assign w_timeout = w_busy && (r_timeout_count == LP_TIMEOUT);
`else
    // Budget parameter only matters in the timeout build
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign w_timeout = 1'b0;
`endif

    // Main FSM: latch request, issue read, collect data, offer it for one cycle
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state           <= ST_IDLE;
            r_pending_address <= '0;
            r_data            <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (request_enable) begin
                        r_pending_address <= word_align(request_address);
                        r_state           <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (w_timeout) begin
                        r_state <= ST_IDLE;
                    end else if (!avm_waitrequest) begin
                        // A slave returning data in the accept cycle is tolerated
                        if (avm_readdatavalid) begin
                            r_data  <= avm_readdata;
                            r_state <= ST_RESPOND;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_timeout) begin
                        r_state <= ST_IDLE;
                    end else if (avm_readdatavalid) begin
                        r_data  <= avm_readdata;
                        r_state <= ST_RESPOND;
                    end
                end
                ST_RESPOND: r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    // Only hand the word back if the cache is still asking for that same word;
    // a withdrawn or redirected request lets the read finish silently.
    assign data_valid    = (r_state == ST_RESPOND) && request_enable &&
                           (word_align(request_address) == r_pending_address);
    assign data          = r_data;
    assign avm_read      = (r_state == ST_READ);
    assign avm_address   = r_pending_address;
    assign timeout_error = w_timeout;

endmodule

// File: tb/tb_memory_reader.sv
// Directed bench for memory_reader: expected words are queued as stimulus is
// issued and a forked monitor pops them whenever data_valid is seen.
// Protocol timing (read strobe, address, suppression, reset) is checked inline.
module tb_memory_reader;

    logic        clock;
    logic        reset_n;
    logic        request_enable;
    logic [31:0] request_address;
    logic        data_valid;
    logic [31:0] data;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        timeout_error;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic        flag;

    memory_reader #(.TIMEOUT_CYCLES(8)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .request_enable    (request_enable),
        .request_address   (request_address),
        .data_valid        (data_valid),
        .data              (data),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .timeout_error     (timeout_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard side: every data_valid pulse must match the oldest queued word
    task automatic monitor();
        logic [31:0] e;
        forever begin
            @(negedge clock);
            if (data_valid === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_unexpected: data_valid with data %h, expected no response", data);
                end else begin
                    e = exp_q.pop_front();
                    if (data !== e) begin
                        n_bad++;
                        $display("FAIL sb_data: got %h, expected %h", data, e);
                    end
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk1 ({tag, "_dv"},    data_valid,    1'b0);
        chk32({tag, "_data"},  data,          32'h0);
        chk1 ({tag, "_read"},  avm_read,      1'b0);
        chk32({tag, "_addr"},  avm_address,   32'h0);
        chk1 ({tag, "_tmo"},   timeout_error, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; request_enable = 1'b0; request_address = '0;
        avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
        fork
            monitor();
        join_none

        tick(); tick();
        check_all_zero("rst");
        reset_n = 1'b1;
        tick();

        // Zero-wait slave
        request_enable = 1'b1; request_address = 32'h0000_0104;
        tick();                                             // READ
        chk1 ("s1_read", avm_read, 1'b1);
        chk32("s1_addr", avm_address, 32'h0000_0104);
        tick();                                             // WAIT
        chk1 ("s1_read_drop", avm_read, 1'b0);
        avm_readdatavalid = 1'b1; avm_readdata = 32'hDEAD_BEEF;
        exp_q.push_back(32'hDEAD_BEEF);
        tick();                                             // RESPOND
        avm_readdatavalid = 1'b0; avm_readdata = '0;
        chk1 ("s1_dv", data_valid, 1'b1);
        chk32("s1_data", data, 32'hDEAD_BEEF);
        tick();                                             // IDLE
        request_enable = 1'b0;
        chk1 ("s1_idle_dv", data_valid, 1'b0);
        tick();
        chk1 ("s1_no_dup", avm_read, 1'b0);

        // Four-cycle waitrequest stall, with a stray readdatavalid during it
        request_enable = 1'b1; request_address = 32'h0000_0208; avm_waitrequest = 1'b1;
        tick();                                             // READ, stalled
        flag = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (avm_read !== 1'b1 || avm_address !== 32'h0000_0208) flag = 1'b0;
            avm_readdatavalid = (i == 1);
            avm_readdata      = 32'hBAD0_0000;
            tick();
        end
        avm_readdatavalid = 1'b0; avm_readdata = '0;
        if (avm_read !== 1'b1 || avm_address !== 32'h0000_0208) flag = 1'b0;
        chk1("s2_stable", flag, 1'b1);
        avm_waitrequest = 1'b0;
        tick();                                             // WAIT
        chk1("s2_read_drop", avm_read, 1'b0);
        avm_readdatavalid = 1'b1; avm_readdata = 32'hCAFE_0001;
        exp_q.push_back(32'hCAFE_0001);
        chk1("s2_dv_not_early", data_valid, 1'b0);
        tick();                                             // RESPOND
        avm_readdatavalid = 1'b0; avm_readdata = '0;
        chk1("s2_dv", data_valid, 1'b1);
        tick();
        request_enable = 1'b0;
        tick();

        // Request redirected during WAIT: old read completes silently
        request_enable = 1'b1; request_address = 32'h0000_0100;
        tick();                                             // READ
        tick();                                             // WAIT
        request_address = 32'h0000_0200;
        tick();
        avm_readdatavalid = 1'b1; avm_readdata = 32'h1111_0100;
        tick();                                             // RESPOND
        avm_readdatavalid = 1'b0; avm_readdata = '0;
        chk1 ("s3_suppressed", data_valid, 1'b0);
        chk32("s3_data_held", data, 32'h1111_0100);
        tick();                                             // IDLE
        chk1 ("s3_idle_gap", avm_read, 1'b0);
        tick();                                             // READ for new line
        chk1 ("s3_reissue", avm_read, 1'b1);
        chk32("s3_new_addr", avm_address, 32'h0000_0200);
        tick();                                             // WAIT
        avm_readdatavalid = 1'b1; avm_readdata = 32'h2222_0200;
        exp_q.push_back(32'h2222_0200);
        tick();                                             // RESPOND
        avm_readdatavalid = 1'b0; avm_readdata = '0;
        chk1 ("s3_dv", data_valid, 1'b1);
        tick();
        request_enable = 1'b0;
        tick();

        // Unaligned request address
        request_enable = 1'b1; request_address = 32'h0000_0107;
        tick();
        chk32("s5_aligned_addr", avm_address, 32'h0000_0104);
        tick();
        avm_readdatavalid = 1'b1; avm_readdata = 32'h0107_0107;
        exp_q.push_back(32'h0107_0107);
        tick();
        avm_readdatavalid = 1'b0; avm_readdata = '0;
        chk1 ("s5_dv", data_valid, 1'b1);
        tick();
        request_enable = 1'b0;
        tick();

        // Slave returning data in the same cycle it accepts the read
        request_enable = 1'b1; request_address = 32'h0000_0400;
        tick();                                             // READ
        avm_readdatavalid = 1'b1; avm_readdata = 32'h4444_0400;
        exp_q.push_back(32'h4444_0400);
        tick();                                             // RESPOND directly
        avm_readdatavalid = 1'b0; avm_readdata = '0;
        chk1 ("s6_dv", data_valid, 1'b1);
        tick();
        request_enable = 1'b0;
        tick();

        // Reset pulse during WAIT, then a late readdatavalid
        request_enable = 1'b1; request_address = 32'h0000_0300;
        tick();                                             // READ
        tick();                                             // WAIT
        reset_n = 1'b0;
        tick();
        check_all_zero("s4");
        reset_n = 1'b1; request_enable = 1'b0;
        tick();
        avm_readdatavalid = 1'b1; avm_readdata = 32'h3333_0300;
        tick();
        avm_readdatavalid = 1'b0; avm_readdata = '0;
        chk1 ("s4_late_dv", data_valid, 1'b0);
        chk32("s4_late_data", data, 32'h0);
        chk1 ("s4_late_read", avm_read, 1'b0);
        tick();

`ifdef MEMORY_READER_TIMEOUT_EN
        // Silent slave: abort 8 cycles after issue, then re-issue
        request_enable = 1'b1; request_address = 32'h0000_0500;
        tick();                                             // READ issued
        flag = 1'b0;
        for (int c = 1; c < 9; c++) begin
            if (timeout_error !== 1'b0) flag = 1'b1;
            tick();
        end
        chk1("to_not_early", flag, 1'b0);
        chk1("to_pulse", timeout_error, 1'b1);
        chk1("to_no_dv", data_valid, 1'b0);
        tick();                                             // IDLE
        chk1("to_single", timeout_error, 1'b0);
        chk1("to_idle", avm_read, 1'b0);
        avm_readdatavalid = 1'b1; avm_readdata = 32'h5555_DEAD;
        tick();                                             // READ again
        avm_readdatavalid = 1'b0; avm_readdata = '0;
        chk1 ("to_reissue", avm_read, 1'b1);
        chk32("to_reissue_addr", avm_address, 32'h0000_0500);
        tick();
        avm_readdatavalid = 1'b1; avm_readdata = 32'h5555_0500;
        exp_q.push_back(32'h5555_0500);
        tick();
        avm_readdatavalid = 1'b0; avm_readdata = '0;
        chk1 ("to_dv", data_valid, 1'b1);
        tick();
        request_enable = 1'b0;
        tick();
`else
        // Slow slave: no abort, the reader simply keeps waiting
        request_enable = 1'b1; request_address = 32'h0000_0500;
        tick();                                             // READ
        tick();                                             // WAIT
        flag = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (timeout_error !== 1'b0 || avm_read !== 1'b0 || data_valid !== 1'b0) flag = 1'b1;
            tick();
        end
        chk1("slow_no_abort", flag, 1'b0);
        avm_readdatavalid = 1'b1; avm_readdata = 32'h5555_0500;
        exp_q.push_back(32'h5555_0500);
        tick();
        avm_readdatavalid = 1'b0; avm_readdata = '0;
        chk1("slow_dv", data_valid, 1'b1);
        tick();
        request_enable = 1'b0;
        tick();
`endif

        tick();
        chk32("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
